id_exe_reg: RTL
===============

// Module: id_exe_reg
// PURPOSE
//  ID->EXE pipeline register of the 5-stage RV32I core. Captures decoded instruction, operands and
//  write-back control from the decode stage; holds on EXE stall, inserts a bubble on load-use stall,
//  squashes on taken branch/jump. Drives the load-hazard feedback (pre_inst_is_load_o, exe_rd_o) to decode.
//  Counts inserted bubbles and flushes for performance visibility.
// PARAMETERS
//  ADDR_WIDTH   32  instruction address width
//  DATA_WIDTH   32  instruction / operand width
//  RADDR_WIDTH  5   register-file address width
//  CNT_WIDTH    32  width of perf counters
// PORTS
//  clk_i              in   1            core clock, all state on rising edge
//  rst_n_i            in   1            asynchronous, active-low reset
//  inst_i             in   DATA_WIDTH   decoded instruction word from ID
//  inst_addr_i        in   ADDR_WIDTH   PC of inst_i
//  op1_i / op2_i      in   DATA_WIDTH   forwarded operands from ID
//  reg_we_i           in   1            rd write enable from ID
//  reg_waddr_i        in   RADDR_WIDTH  rd address from ID
//  stall_id_i         in   1            ID held this cycle (load-use stall request)
//  stall_exe_i        in   1            EXE held this cycle (multi-cycle op / memory wait)
//  flush_i            in   1            branch/jump taken in EXE: squash younger inst
//  cnt_clr_i          in   1            synchronous clear of both perf counters
//  inst_o             out  DATA_WIDTH   registered instruction to EXE
//  inst_addr_o        out  ADDR_WIDTH   registered PC
//  op1_o / op2_o      out  DATA_WIDTH   registered operands
//  reg_we_o           out  1            registered rd write enable
//  reg_waddr_o        out  RADDR_WIDTH  registered rd address
//  valid_o            out  1            1 = real instruction, 0 = bubble
//  pre_inst_is_load_o out  1            registered inst is a load writing rd!=x0
//  exe_rd_o           out  RADDR_WIDTH  equals reg_waddr_o (hazard compare in ID)
//  bubble_cnt_o       out  CNT_WIDTH    bubbles inserted by load-use stall
//  flush_cnt_o        out  CNT_WIDTH    flushes applied
// BEHAVIOUR
//  - Reset (rst_n_i=0, async, any time incl. mid-stall): inst_o=NOP (32'h00000013), inst_addr_o=0,
//    op1_o=op2_o=0, reg_we_o=0, reg_waddr_o=0, valid_o=0, pre_inst_is_load_o=0, counters=0.
//  - Per-edge update, strict priority:
//    1. flush_i=1         -> load BUBBLE (NOP, addr 0, ops 0, we 0, waddr 0, valid 0); flush_cnt++.
//    2. stall_exe_i=1     -> hold all registers unchanged; no counter change.
//    3. stall_id_i=1      -> load BUBBLE; bubble_cnt++.
//    4. otherwise         -> capture all inputs, valid_o=1.
//  - Flush wins over both stalls on the same edge; only flush_cnt increments then.
//  - Latency: input visible on outputs 1 cycle after capture edge; no combinational in->out paths.
//  - pre_inst_is_load_o registered alongside data: set iff captured inst_i[6:0]==7'b0000011 and
//    reg_we_i=1 and reg_waddr_i!=0; cleared by bubble/flush; held on stall_exe_i. Excluding x0
//    prevents spurious load-use stalls.
//  - exe_rd_o = reg_waddr_o (wire).
//  - Counters: wrap modulo 2^CNT_WIDTH; cnt_clr_i clears both and overrides any same-cycle
//    increment; counters keep counting while stall_exe_i holds the data registers only if flush_i.
// STRUCTURE
//  - Shared defines header: ADDR/DATA/RADDR widths, NOP, ZERO, ZERO_REG, WRITE_ENABLE/DISABLE,
//    INST_TYPE_L opcode; reuse existing entries, add none local.
//  - One sub-module: perf_cnt (CNT_WIDTH, inc_i, clr_i, cnt_o; async active-low reset), instanced
//    twice. Data/control registers in a single priority-encoded sequential process.
// TESTING
//  - Reset mid-run: capture addi at PC 0x40, drop rst_n_i between edges -> outputs NOP/0 immediately.
//  - Normal flow: inst 0x00500093 @0x10, op1=5 -> next edge inst_o=0x00500093, valid_o=1, we=1, rd=1.
//  - Load-use: lw x5 (0x0002A283) captured -> pre_inst_is_load_o=1, exe_rd_o=5; then stall_id_i=1
//    -> bubble (valid_o=0, we=0), bubble_cnt_o=1.
//  - lw x0 (0x00002003) captured -> pre_inst_is_load_o=0.
//  - stall_exe_i=1 for 3 cycles with changing inputs -> outputs frozen, counters unchanged.
//  - flush_i+stall_exe_i+stall_id_i same edge -> bubble, flush_cnt_o=1, bubble_cnt_o unchanged;
//    preload counter 0xFFFFFFFF + flush -> wraps to 0; cnt_clr_i with flush -> 0.

Source files
------------

// File: rtl/id_exe_reg_pkg.sv
// Shared RV32I core definitions: datapath widths, canonical encodings and
// the load-detection helper used by the ID->EXE pipeline register.
package id_exe_reg_pkg;

  localparam int ADDR_WIDTH  = 32;
  localparam int DATA_WIDTH  = 32;
  localparam int RADDR_WIDTH = 5;

  localparam logic [31:0] NOP           = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic [31:0] ZERO          = 32'h0000_0000;
  localparam logic [4:0]  ZERO_REG      = 5'd0;
  localparam logic        WRITE_ENABLE  = 1'b1;
  localparam logic        WRITE_DISABLE = 1'b0;
  localparam logic [6:0]  INST_TYPE_L   = 7'b0000011;

  // A load only creates a hazard if it actually writes a real register.
  function automatic logic is_load_wr(input logic [6:0] opcode,
                                      input logic       we,
                                      input logic       rd_nonzero);
    return (opcode == INST_TYPE_L) && (we == WRITE_ENABLE) && rd_nonzero;
  endfunction

endpackage

// File: rtl/id_exe_reg_perf_cnt.sv
// Wrapping event counter with a synchronous clear that overrides increment.
module perf_cnt #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 inc_i,
  input  logic                 clr_i,
  output logic [CNT_WIDTH-1:0] cnt_o
);

  logic [CNT_WIDTH-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/id_exe_reg.sv
// ID->EXE pipeline register: capture, hold on EXE stall, bubble on load-use
// stall, squash on flush; exports load-hazard feedback and perf counters.
module id_exe_reg
  import id_exe_reg_pkg::*;
#(
  parameter int ADDR_WIDTH  = id_exe_reg_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH  = id_exe_reg_pkg::DATA_WIDTH,
  parameter int RADDR_WIDTH = id_exe_reg_pkg::RADDR_WIDTH,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [DATA_WIDTH-1:0]  inst_i,
  input  logic [ADDR_WIDTH-1:0]  inst_addr_i,
  input  logic [DATA_WIDTH-1:0]  op1_i,
  input  logic [DATA_WIDTH-1:0]  op2_i,
  input  logic                   reg_we_i,
  input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
  input  logic                   stall_id_i,
  input  logic                   stall_exe_i,
  input  logic                   flush_i,
  input  logic                   cnt_clr_i,
  output logic [DATA_WIDTH-1:0]  inst_o,
  output logic [ADDR_WIDTH-1:0]  inst_addr_o,
  output logic [DATA_WIDTH-1:0]  op1_o,
  output logic [DATA_WIDTH-1:0]  op2_o,
  output logic                   reg_we_o,
  output logic [RADDR_WIDTH-1:0] reg_waddr_o,
  output logic                   valid_o,
  output logic                   pre_inst_is_load_o,
  output logic [RADDR_WIDTH-1:0] exe_rd_o,
  output logic [CNT_WIDTH-1:0]   bubble_cnt_o,
  output logic [CNT_WIDTH-1:0]   flush_cnt_o
);

  logic [DATA_WIDTH-1:0]  inst_q;
  logic [ADDR_WIDTH-1:0]  inst_addr_q;
  logic [DATA_WIDTH-1:0]  op1_q, op2_q;
  logic                   reg_we_q;
  logic [RADDR_WIDTH-1:0] reg_waddr_q;
  logic                   valid_q;
  logic                   is_load_q;
  logic                   is_load_d;
  logic                   bubble_inc;

  assign is_load_d  = is_load_wr(inst_i[6:0], reg_we_i,
                                 reg_waddr_i != RADDR_WIDTH'(ZERO_REG));
  // Load-use bubbles are only inserted when neither a flush nor an EXE hold wins.
  assign bubble_inc = stall_id_i && !stall_exe_i && !flush_i;

  // NOTE: every pipeline flop is async-reset to the bubble state so EXE never sees X after reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      inst_q      <= DATA_WIDTH'(NOP);
      inst_addr_q <= ADDR_WIDTH'(ZERO);
      op1_q       <= DATA_WIDTH'(ZERO);
      op2_q       <= DATA_WIDTH'(ZERO);
      reg_we_q    <= WRITE_DISABLE;
      reg_waddr_q <= RADDR_WIDTH'(ZERO_REG);
      valid_q     <= 1'b0;
      is_load_q   <= 1'b0;
    end else if (flush_i || (stall_id_i && !stall_exe_i)) begin
      inst_q      <= DATA_WIDTH'(NOP);
      inst_addr_q <= ADDR_WIDTH'(ZERO);
      op1_q       <= DATA_WIDTH'(ZERO);
      op2_q       <= DATA_WIDTH'(ZERO);
      reg_we_q    <= WRITE_DISABLE;
      reg_waddr_q <= RADDR_WIDTH'(ZERO_REG);
      valid_q     <= 1'b0;
      is_load_q   <= 1'b0;
    end else if (!stall_exe_i) begin
      inst_q      <= inst_i;
      inst_addr_q <= inst_addr_i;
      op1_q       <= op1_i;
      op2_q       <= op2_i;
      reg_we_q    <= reg_we_i;
      reg_waddr_q <= reg_waddr_i;
      valid_q     <= 1'b1;
      is_load_q   <= is_load_d;
    end
  end

  assign inst_o             = inst_q;
  assign inst_addr_o        = inst_addr_q;
  assign op1_o              = op1_q;
  assign op2_o              = op2_q;
  assign reg_we_o           = reg_we_q;
  assign reg_waddr_o        = reg_waddr_q;
  assign valid_o            = valid_q;
  assign pre_inst_is_load_o = is_load_q;
  assign exe_rd_o           = reg_waddr_q;

  perf_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_bubble_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .inc_i   (bubble_inc),
    .clr_i   (cnt_clr_i),
    .cnt_o   (bubble_cnt_o)
  );

  perf_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .inc_i   (flush_i),
    .clr_i   (cnt_clr_i),
    .cnt_o   (flush_cnt_o)
  );

endmodule
